fetch_prefetch_unit: RTL and testbench
======================================

# fetch_prefetch_unit

Instruction-fetch front end for the 8-bit pipelined core: owns the program counter, drives the combinational instruction memory, and buffers fetched instructions with their PCs in a small prefetch queue. It sits directly upstream of the IF/ID pipeline register. It replaces the free-running PC counter with a design that stalls on back-pressure and redirects on taken branches/jumps.

## Interface
Parameters:
- DEPTH, 4, prefetch queue entries (power of two, ≥2)
- PC_INC, 4, PC increment per sequential fetch (byte-addressed 32-bit instructions)
- RESET_PC, 8'h00, PC value loaded on reset

Ports:
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock; polarity/synchronicity fixed
- imem_addr  out  8  fetch address to instruction memory (= fetch_pc)
- imem_rdata  in  32  instruction at imem_addr, same-cycle combinational read
- redirect_valid  in  1  taken branch/jump from EX; flush and refetch
- redirect_pc  in  8  new fetch address, sampled when redirect_valid=1
- out_valid  out  1  queue head holds a valid instruction
- out_ready  in  1  IF/ID accepts (deasserted by hazard stall)
- out_inst  out  32  queue head instruction
- out_pc  out  8  PC of queue head instruction

## Operation
- State: fetch_pc (8 b), queue of DEPTH entries {pc[7:0], inst[31:0]}, wr_ptr, rd_ptr (log2 DEPTH b), count (log2 DEPTH + 1 b).
- Reset: fetch_pc=RESET_PC, pointers=0, count=0. Outputs: out_valid=0, out_inst=0, out_pc=0, imem_addr=RESET_PC.
- pop = out_valid & out_ready.
- push = !redirect_valid & (count<DEPTH | pop). Push writes {fetch_pc, imem_rdata} at wr_ptr; fetch_pc += PC_INC, modulo 256 (255+4 → 3; no trap).
- Full with simultaneous pop: push and pop both occur; count unchanged.
- Full without pop: no push; fetch_pc holds; imem_addr stable.
- Empty: out_valid=0; out_inst=0, out_pc=0 (muxed, not stale entry).
- Redirect, highest priority: queue flushed (count=0, pointers=0), fetch_pc=redirect_pc, no push, no pop. out_valid forced 0 combinationally during the redirect cycle, so IF/ID never captures a wrong-path instruction.
- Redirect while full or empty: same behaviour.
- reset with redirect_valid: reset wins; fetch_pc=RESET_PC.
- Pointers wrap modulo DEPTH; count never exceeds DEPTH or underflows.

## Timing
- Fetch-to-output latency: 1 cycle. An instruction pushed in cycle N appears on out_* in cycle N+1.
- After reset deasserts (cycle 0 = first non-reset edge), out_valid=1 from cycle 1 with out_pc=RESET_PC.
- Redirect asserted in cycle N: out_valid=0 in N; first push from redirect_pc in N+1; out_valid=1, out_pc=redirect_pc in N+2. Redirect penalty: 2 cycles of bubbles at the output.
- Sustained throughput with out_ready=1: one instruction per cycle, PCs consecutive by PC_INC.
- Stall: with out_ready=0, queue fills DEPTH entries, then fetch halts. On out_ready rising, output resumes the next cycle with no lost or duplicated PCs.
- Combinational paths: out_ready→push (full case), redirect_valid→out_valid. No path from imem_rdata to any output.

## Structure
- Shared package (core_pkg): PC_W=8, INST_W=32, RESET_PC, NOP_INST=32'h0000_0013, prefetch entry struct {pc, inst}.
- Sub-module fetch_queue: synchronous FIFO with push/pop/flush, count, head data. fetch_prefetch_unit holds fetch_pc, push/redirect logic and output muxing.
- Top-level replaces the PC counter + IF/ID pc input with imem_addr / out_pc / out_inst. IF/ID enable = out_ready; IF/ID flush = redirect_valid.

## Test plan
- Reset then out_ready=1, imem[k]=32'hA000_0000+k → out_pc 0x00,0x04,0x08,… each cycle from cycle 1, out_inst matches; out_valid=1 continuously.
- Hold out_ready=0 for 10 cycles → exactly DEPTH=4 pushes (pc 0x00–0x0C), imem_addr frozen at 0x10; release → outputs 0x00,0x04,0x08,0x0C,0x10,… with no gap or duplicate.
- redirect_valid=1, redirect_pc=0x40 while queue holds 3 entries → out_valid=0 that cycle and next; out_pc=0x40 two cycles later, then 0x44.
- Sequential fetch from 0xF8 → PCs 0xF8,0xFC,0x00,0x04 (wrap modulo 256).
- Full queue with out_ready=1 → push and pop in the same cycle; count stays 4; one instruction per cycle.
- reset asserted mid-stream together with redirect_valid=1 → next cycle out_valid=0, out_inst=0, out_pc=0, imem_addr=RESET_PC.

Source files
------------

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared widths, reset PC and prefetch entry type for the 8-bit core
package core_pkg;

   localparam int PC_W   = 8;
   localparam int INST_W = 32;

   localparam logic [PC_W-1:0]   RESET_PC = 8'h00;
   localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic [INST_W-1:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - prefetch FIFO of {pc, inst} entries with push/pop/flush
module fetch_queue
   import core_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               push,
   input  fetch_entry_t       push_entry,
   input  logic               pop,
   input  logic               flush,
   output logic [CNT_W-1:0]   count,
   output fetch_entry_t       head
);

   fetch_entry_t             mem_q [DEPTH];
   fetch_entry_t             mem_d [DEPTH];
   logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]         count_q, count_d;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         // DEPTH is a power of two, so pointer increments wrap naturally
         if (push) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign count = count_q;
   assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_prefetch_unit.sv
// rtl/fetch_prefetch_unit.sv - PC owner, imem driver and prefetch queue front end
module fetch_prefetch_unit
   import core_pkg::*;
#(
   parameter int              DEPTH    = 4,
   parameter int              PC_INC   = 4,
   parameter logic [PC_W-1:0] RESET_PC = core_pkg::RESET_PC
) (
   input  logic              clk,
   input  logic              reset,
   output logic [PC_W-1:0]   imem_addr,
   input  logic [INST_W-1:0] imem_rdata,
   input  logic              redirect_valid,
   input  logic [PC_W-1:0]   redirect_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [INST_W-1:0] out_inst,
   output logic [PC_W-1:0]   out_pc
);

   localparam int              CNT_W   = $clog2(DEPTH) + 1;
   localparam logic [PC_W-1:0] PC_STEP = PC_W'(PC_INC);

   logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
   logic [CNT_W-1:0] count;
   fetch_entry_t     head;
   fetch_entry_t     push_entry;
   logic             full;
   logic             push;
   logic             pop;

   always_comb begin
      full       = (count == CNT_W'(DEPTH));
      // Redirect masks the head so IF/ID never latches a wrong-path instruction
      out_valid  = (count != '0) && !redirect_valid;
      pop        = out_valid && out_ready;
      push       = !redirect_valid && (!full || pop);
      push_entry = '{pc: fetch_pc_q, inst: imem_rdata};
      out_inst   = out_valid ? head.inst : '0;
      out_pc     = out_valid ? head.pc   : '0;

      fetch_pc_d = fetch_pc_q;
      if (redirect_valid) begin
         fetch_pc_d = redirect_pc;
      end else if (push) begin
         fetch_pc_d = fetch_pc_q + PC_STEP;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q <= RESET_PC;
      end else begin
         fetch_pc_q <= fetch_pc_d;
      end
   end

   assign imem_addr = fetch_pc_q;

   fetch_queue #(
      .DEPTH (DEPTH)
   ) u_fetch_queue (
      .clk        (clk),
      .reset      (reset),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .flush      (redirect_valid),
      .count      (count),
      .head       (head)
   );

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb/tb_fetch_prefetch_unit.sv - directed and randomized bench for fetch_prefetch_unit
module tb_fetch_prefetch_unit;

   localparam int DEPTH = 4;

   typedef struct {
      logic [7:0]  pc;
      logic [31:0] inst;
   } ref_entry_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  imem_addr;
   logic [31:0] imem_rdata;
   logic        redirect_valid = 1'b0;
   logic [7:0]  redirect_pc = 8'h00;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_inst;
   logic [7:0]  out_pc;

   int checks = 0;
   int failures = 0;

   ref_entry_t  ref_q[$];
   logic [7:0]  ref_pc = 8'h00;

   logic        obs_valid;
   logic [7:0]  obs_pc;
   logic [31:0] obs_inst;
   logic [7:0]  obs_addr;

   always #5 clk = ~clk;

   assign imem_rdata = 32'hA000_0000 + {24'd0, imem_addr};

   fetch_prefetch_unit #(
      .DEPTH    (DEPTH),
      .PC_INC   (4),
      .RESET_PC (8'h00)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_inst       (out_inst),
      .out_pc         (out_pc)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // One cycle: drive inputs, compare outputs against the queue model, then advance the model
   task automatic step(input logic rst, input logic rv, input logic [7:0] rpc, input logic rdy);
      logic        exp_valid;
      logic        do_pop;
      logic        do_push;
      ref_entry_t  e;
      @(negedge clk);
      reset          = rst;
      redirect_valid = rv;
      redirect_pc    = rpc;
      out_ready      = rdy;
      #1;
      exp_valid = (ref_q.size() != 0) && !rv;
      obs_valid = out_valid;
      obs_pc    = out_pc;
      obs_inst  = out_inst;
      obs_addr  = imem_addr;
      check("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
      check("out_pc",    {24'd0, out_pc},    exp_valid ? {24'd0, ref_q[0].pc} : 32'd0);
      check("out_inst",  out_inst,           exp_valid ? ref_q[0].inst : 32'd0);
      check("imem_addr", {24'd0, imem_addr}, {24'd0, ref_pc});
      @(posedge clk);
      if (rst) begin
         ref_q.delete();
         ref_pc = 8'h00;
      end else if (rv) begin
         ref_q.delete();
         ref_pc = rpc;
      end else begin
         do_pop  = exp_valid && rdy;
         do_push = (ref_q.size() < DEPTH) || do_pop;
         if (do_pop) void'(ref_q.pop_front());
         if (do_push) begin
            e.pc   = ref_pc;
            e.inst = 32'hA000_0000 + {24'd0, ref_pc};
            ref_q.push_back(e);
            ref_pc = ref_pc + 8'd4;
         end
      end
   endtask

   initial begin
      // Streaming from reset: cycle 0 empty, then consecutive PCs each cycle
      step(1, 0, 8'h00, 1);
      step(1, 0, 8'h00, 1);
      check("rst_valid", {31'd0, obs_valid}, 32'd0);
      check("rst_addr",  {24'd0, obs_addr},  32'd0);
      for (int i = 0; i < 8; i++) begin
         step(0, 0, 8'h00, 1);
         if (i >= 1) begin
            check("seq_valid", {31'd0, obs_valid}, 32'd1);
            check("seq_pc",    {24'd0, obs_pc},    32'((i - 1) * 4));
            check("seq_inst",  obs_inst,           32'hA000_0000 + 32'((i - 1) * 4));
         end
      end

      // Stall fills exactly DEPTH entries and freezes imem_addr, release drains without gaps
      step(1, 0, 8'h00, 0);
      for (int i = 0; i < 10; i++) step(0, 0, 8'h00, 0);
      check("stall_addr", {24'd0, obs_addr}, 32'h10);
      check("stall_head", {24'd0, obs_pc},   32'h00);
      for (int i = 0; i < 6; i++) begin
         step(0, 0, 8'h00, 1);
         check("drain_pc", {24'd0, obs_pc}, 32'(i * 4));
      end

      // Redirect with three entries queued
      step(1, 0, 8'h00, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 0);
      step(0, 1, 8'h40, 1);
      check("redir_n0", {31'd0, obs_valid}, 32'd0);
      step(0, 0, 8'h00, 1);
      check("redir_n1", {31'd0, obs_valid}, 32'd0);
      step(0, 0, 8'h00, 1);
      check("redir_n2_pc", {24'd0, obs_pc}, 32'h40);
      step(0, 0, 8'h00, 1);
      check("redir_n3_pc", {24'd0, obs_pc}, 32'h44);

      // PC wraps modulo 256
      step(0, 1, 8'hF8, 1);
      step(0, 0, 8'h00, 1);
      step(0, 0, 8'h00, 1);
      check("wrap_f8", {24'd0, obs_pc}, 32'hF8);
      step(0, 0, 8'h00, 1);
      check("wrap_fc", {24'd0, obs_pc}, 32'hFC);
      step(0, 0, 8'h00, 1);
      check("wrap_00", {24'd0, obs_pc}, 32'h00);
      step(0, 0, 8'h00, 1);
      check("wrap_04", {24'd0, obs_pc}, 32'h04);

      // Reset together with redirect: reset wins
      step(1, 1, 8'h80, 1);
      step(0, 0, 8'h00, 0);
      check("rr_valid", {31'd0, obs_valid}, 32'd0);
      check("rr_inst",  obs_inst,           32'd0);
      check("rr_pc",    {24'd0, obs_pc},    32'd0);
      check("rr_addr",  {24'd0, obs_addr},  32'd0);

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 49) == 0),
              ($urandom_range(0, 9) == 0),
              8'($urandom),
              ($urandom_range(0, 3) != 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
